// File: rtl/pixel_mem_pkg.sv
// pixel_mem_pkg
// Shared types for the frame-memory arbiter: FSM state encoding, requester
// index constants and the control part of a pending-request slot.
package pixel_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_t;

  localparam int REQ_PROC = 0;  // pixel-processing engine (read/write)
  localparam int REQ_SCAN = 1;  // display scan-out reader (read-only)

  // Control bits of a pending slot. The address/data payload is held next to
  // it in the top because its width is a per-instance parameter.
  // oor = address was out of range when the request was latched.
  typedef struct packed {
    logic valid;
    logic is_write;
    logic oor;
  } pend_slot_t;

endpackage

// File: rtl/pixel_mem_arb_rr_arb2.sv
// rr_arb2
// Two-way round-robin grant. On a tie the requester that was not granted last
// wins; a lone request is granted regardless of the pointer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_req      : request vector, one bit per requester
//   i_advance  : take the current grant (pointer updates if any request)
//   o_gnt      : one-hot grant (combinational from i_req and pointer)
//   o_last     : index of the most recently granted requester (reset 1)
module rr_arb2
  import pixel_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt,
  output logic       o_last
);

  logic r_last;

  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_advance && |i_req) begin
      r_last <= o_gnt[REQ_SCAN];
    end
  end

  assign o_last = r_last;

endmodule

// File: rtl/pixel_mem_arb.sv
// pixel_mem_arb
// Arbiter for the single-port RGB frame memory. Requester 0 (processing)
// issues read/write pulses, requester 1 (scan-out) issues read pulses. Each
// requester has one pending slot; slots are granted round-robin and served
// through a registered RAM port with one cycle of read latency.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   req0_rd/wr/addr/wdata      : processing request pulse and payload
//   req0_val/rdata, req0_done  : processing read data pulse / write complete
//   req1_rd/addr               : scan-out read pulse and address
//   req1_val/rdata             : scan-out read data pulse
//   mem_en/we/addr/wdata       : registered RAM port
//   mem_rdata                  : RAM read data, one cycle after a read issue
//   err                        : sticky protocol / address-range error
module pixel_mem_arb
  import pixel_mem_pkg::*;
#(
  parameter int V_SIZE = 256,
  parameter int H_SIZE = 256,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_rd,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_val,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_done,
  input  logic              req1_rd,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_val,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  // One extra bit so a full 2^ADDR_W image does not wrap to zero.
  localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(V_SIZE * H_SIZE);

  arb_state_t        r_state;
  logic              r_mem_en, r_mem_we, r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_val, r_done;
  logic [DATA_W-1:0] r_rdata [2];

  logic [1:0]        w_rd, w_wr, w_pulse, w_clr, w_drop, w_req, w_gnt;
  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_wdata [2];
  pend_slot_t        w_slot [2];
  logic [ADDR_W-1:0] w_slot_addr [2];
  logic [DATA_W-1:0] w_slot_wdata [2];
  logic              w_last, w_sel;
  pend_slot_t        w_cur;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [DATA_W-1:0] w_cur_wdata;

  // Uniform per-requester view; scan-out never writes.
  assign w_rd[REQ_PROC]    = req0_rd;
  assign w_wr[REQ_PROC]    = req0_wr;
  assign w_addr[REQ_PROC]  = req0_addr;
  assign w_wdata[REQ_PROC] = req0_wdata;
  assign w_rd[REQ_SCAN]    = req1_rd;
  assign w_wr[REQ_SCAN]    = 1'b0;
  assign w_addr[REQ_SCAN]  = req1_addr;
  assign w_wdata[REQ_SCAN] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      pend_slot_t        r_slot;
      logic [ADDR_W-1:0] r_addr;
      logic [DATA_W-1:0] r_wdata;

      assign w_pulse[gi] = w_rd[gi] | w_wr[gi];
      // Slot frees on the write-issue edge or the capture edge of its own
      // access; during service the arbiter pointer names the owner.
      assign w_clr[gi]   = (w_last == 1'(gi)) &&
                           ((r_state == ST_ISSUE && r_slot.is_write) ||
                            (r_state == ST_CAPTURE));
      // A pulse on the freeing edge is accepted, otherwise a busy slot drops it.
      assign w_drop[gi]  = w_pulse[gi] & r_slot.valid & ~w_clr[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_slot  <= '0;
          r_addr  <= '0;
          r_wdata <= '0;
        end else if (w_pulse[gi] && (!r_slot.valid || w_clr[gi])) begin
          r_slot.valid    <= 1'b1;
          r_slot.is_write <= w_wr[gi];  // rd+wr together: write wins
          r_slot.oor      <= ({1'b0, w_addr[gi]} >= NPIX);
          r_addr          <= w_addr[gi];
          r_wdata         <= w_wdata[gi];
        end else if (w_clr[gi]) begin
          r_slot.valid <= 1'b0;
        end
      end

      assign w_slot[gi]       = r_slot;
      assign w_slot_addr[gi]  = r_addr;
      assign w_slot_wdata[gi] = r_wdata;
      assign w_req[gi]        = r_slot.valid;
    end
  endgenerate

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (reset),
    .i_req     (w_req),
    .i_advance (r_state == ST_IDLE),
    .o_gnt     (w_gnt),
    .o_last    (w_last)
  );

  // In IDLE select the slot about to be granted; afterwards the pointer has
  // already moved to it.
  assign w_sel       = (r_state == ST_IDLE) ? w_gnt[REQ_SCAN] : w_last;
  assign w_cur       = w_slot[w_sel];
  assign w_cur_addr  = w_slot_addr[w_sel];
  assign w_cur_wdata = w_slot_wdata[w_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_val       <= '0;
      r_done      <= '0;
      r_rdata[0]  <= '0;
      r_rdata[1]  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_val    <= '0;
      r_done   <= '0;
      r_mem_en <= 1'b0;
      if (|w_drop || (req0_rd && req0_wr)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_state <= ST_ISSUE;
            if (w_cur.oor) begin
              // Out-of-range access walks the normal path with the RAM idle.
              r_err <= 1'b1;
            end else begin
              r_mem_en   <= 1'b1;
              r_mem_we   <= w_cur.is_write;
              r_mem_addr <= w_cur_addr;
              if (w_cur.is_write) begin
                r_mem_wdata <= w_cur_wdata;
              end
            end
          end
        end
        ST_ISSUE: begin
          if (w_cur.is_write) begin
            r_done[w_sel] <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_rdata[w_sel] <= w_cur.oor ? '0 : mem_rdata;
          r_val[w_sel]   <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign req0_val   = r_val[REQ_PROC];
  assign req0_done  = r_done[REQ_PROC];
  assign req0_rdata = r_rdata[REQ_PROC];
  assign req1_val   = r_val[REQ_SCAN];
  assign req1_rdata = r_rdata[REQ_SCAN];
  assign err        = r_err;

endmodule

// File: tb/tb_pixel_mem_arb.sv
// tb_pixel_mem_arb
// Self-checking bench: directed cases followed by randomized traffic on both
// requesters, checked against a transaction-level memory model and the
// latency bounds of the arbiter.
module tb_pixel_mem_arb;

  localparam int AW   = 16;
  localparam int DW   = 24;
  localparam int NPIX = 16;  // 4 x 4 image

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_rd, req0_wr, req1_rd;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_val, req0_done, req1_val;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          err;

  pixel_mem_arb #(.V_SIZE(4), .H_SIZE(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_rd    (req0_rd),
    .req0_wr    (req0_wr),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_val   (req0_val),
    .req0_rdata (req0_rdata),
    .req0_done  (req0_done),
    .req1_rd    (req1_rd),
    .req1_addr  (req1_addr),
    .req1_val   (req1_val),
    .req1_rdata (req1_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Frame RAM attached to the DUT port, and the bench's expected contents.
  logic [DW-1:0] ram     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_pass   = 0;
  int n_checks = 0;
  bit exp_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One request on one port; response latency counted in cycles from the
  // pulse cycle. solo = no other traffic, so RAM-port timing is exact.
  task automatic xact(input int port, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input int lo, input int hi, input bit solo);
    bit            oor;
    bit            seen;
    logic          resp;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] got_d;
    int            lat;
    int            clamp;
    oor   = (int'(addr) >= NPIX);
    exp_d = oor ? '0 : ref_mem[addr];
    if (wr && !oor) ref_mem[addr] = wd;
    @(negedge clk);
    if (port == 0) begin
      req0_rd = !wr; req0_wr = wr; req0_addr = addr; req0_wdata = wd;
    end else begin
      req1_rd = 1'b1; req1_addr = addr;
    end
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (port == 0) begin req0_rd = 1'b0; req0_wr = 1'b0; end
        else req1_rd = 1'b0;
      end
      if (solo) begin
        check("mem_en", 32'(mem_en), 32'(k == 2 && !oor));
        if (k == 2 && !oor) begin
          check("mem_addr", 32'(mem_addr), 32'(addr));
          check("mem_we", 32'(mem_we), 32'(wr));
          if (wr) check("mem_wdata", 32'(mem_wdata), 32'(wd));
        end
      end
      resp  = (port == 0) ? (wr ? req0_done : req0_val) : req1_val;
      got_d = (port == 0) ? req0_rdata : req1_rdata;
      if (resp) begin
        seen  = 1'b1;
        lat   = k;
        clamp = (lat < lo) ? lo : ((lat > hi) ? hi : lat);
        check(port == 0 ? "lat0" : "lat1", 32'(lat), 32'(clamp));
        if (!wr) check(port == 0 ? "rdata0" : "rdata1", 32'(got_d), 32'(exp_d));
        if (oor) check("err_oor", 32'(err), 32'd1);
      end
    end
    if (!seen) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      resp = (port == 0) ? (wr ? req0_done : req0_val) : req1_val;
      check("pulse_len", 32'(resp), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            cnt_v, cnt_d;
    logic [DW-1:0] last_d;
    reset = 1'b1;
    req0_rd = 1'b0; req0_wr = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_rd = 1'b0; req1_addr = '0;
    mem_rdata = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[5]     = 24'hA1B2C3;
    ref_mem[5] = 24'hA1B2C3;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem", 32'({mem_en, mem_we, mem_addr}), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_pulses", 32'({req0_val, req0_done, req1_val}), 32'd0);
    check("rst_rdata0", 32'(req0_rdata), 32'd0);
    check("rst_rdata1", 32'(req1_rdata), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // Single read, then write followed by a scan-out read of the same pixel
    xact(0, 1'b0, 16'd5, '0, 4, 4, 1'b1);
    xact(0, 1'b1, 16'd7, 24'h333333, 3, 3, 1'b1);
    xact(1, 1'b0, 16'd7, '0, 4, 4, 1'b1);
    check("err_clean", 32'(err), 32'd0);

    // Contention with pointer at 1: processing first, scan-out three later
    fork
      xact(0, 1'b0, 16'd2, '0, 4, 4, 1'b0);
      xact(1, 1'b0, 16'd9, '0, 7, 7, 1'b0);
    join
    // Lone processing grant moves the pointer to 0; next tie goes to scan-out
    xact(0, 1'b0, 16'd3, '0, 4, 4, 1'b1);
    fork
      xact(0, 1'b0, 16'd4, '0, 7, 7, 1'b0);
      xact(1, 1'b0, 16'd10, '0, 4, 4, 1'b0);
    join
    check("err_contend", 32'(err), 32'd0);

    // Second read pulse while the first is pending is dropped
    @(negedge clk); req0_rd = 1'b1; req0_addr = 16'd5;
    @(negedge clk); req0_addr = 16'd6;
    @(negedge clk); req0_rd = 1'b0;
    cnt_v = 0; last_d = '0;
    repeat (10) begin
      @(negedge clk);
      if (req0_val) begin cnt_v++; last_d = req0_rdata; end
    end
    check("drop_vals", 32'(cnt_v), 32'd1);
    check("drop_rdata", 32'(last_d), 32'(ref_mem[5]));
    check("drop_err", 32'(err), 32'd1);
    do_reset();
    check("err_cleared", 32'(err), 32'd0);

    // Read and write pulsed together: write taken
    @(negedge clk); req0_rd = 1'b1; req0_wr = 1'b1; req0_addr = 16'd3; req0_wdata = 24'h5A5A5A;
    ref_mem[3] = 24'h5A5A5A;
    @(negedge clk); req0_rd = 1'b0; req0_wr = 1'b0;
    cnt_v = 0; cnt_d = 0;
    repeat (8) begin
      @(negedge clk);
      if (req0_val)  cnt_v++;
      if (req0_done) cnt_d++;
    end
    check("both_done", 32'(cnt_d), 32'd1);
    check("both_noval", 32'(cnt_v), 32'd0);
    check("both_err", 32'(err), 32'd1);
    xact(0, 1'b0, 16'd3, '0, 4, 4, 1'b1);
    do_reset();

    // Out-of-range read and write: RAM untouched, err raised
    xact(1, 1'b0, 16'd16, '0, 4, 4, 1'b1);
    xact(0, 1'b1, 16'd17, 24'h123456, 3, 3, 1'b1);

    // Reset while a write is in ISSUE
    do_reset();
    @(negedge clk); req0_wr = 1'b1; req0_addr = 16'd11; req0_wdata = 24'hDEAD01;
    @(negedge clk); req0_wr = 1'b0;
    @(negedge clk);
    check("issue_en", 32'(mem_en), 32'd1);
    #1 reset = 1'b1;
    #1 check("async_en_off", 32'(mem_en), 32'd0);
    @(negedge clk); reset = 1'b0;
    cnt_d = 0;
    repeat (6) begin
      @(negedge clk);
      if (req0_done) cnt_d++;
    end
    check("rst_nodone", 32'(cnt_d), 32'd0);
    check("rst_err2", 32'(err), 32'd0);
    xact(1, 1'b0, 16'd11, '0, 4, 4, 1'b1);

    // Randomized traffic: processing owns pixels 0..7, scan-out reads 8..15
    exp_err = 1'b0;
    fork
      begin
        bit            wr0;
        logic [AW-1:0] a0;
        for (int i = 0; i < 40; i++) begin
          wr0 = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 9) == 0) begin
            a0 = AW'(16 + $urandom_range(0, 15));
            exp_err = 1'b1;
          end else begin
            a0 = AW'($urandom_range(0, 7));
          end
          xact(0, wr0, a0, DW'($urandom), wr0 ? 3 : 4, wr0 ? 6 : 7, 1'b0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        logic [AW-1:0] a1;
        for (int j = 0; j < 40; j++) begin
          if ($urandom_range(0, 9) == 0) begin
            a1 = AW'(16 + $urandom_range(0, 15));
            exp_err = 1'b1;
          end else begin
            a1 = AW'($urandom_range(8, 15));
          end
          xact(1, 1'b0, a1, '0, 4, 7, 1'b0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join
    check("err_final", 32'(err), 32'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
